// File: rtl/frequency_sweeper_multimode.sv
// frequency_sweeper_multimode: pops sweep instructions from a FIFO and steps a DDS tuning word
// through single, sawtooth-repeat, triangle or triangle-repeat ramps with optional clamping.
module frequency_sweeper_multimode #(
  parameter int FREQ_W = 32,
  parameter int DWELL_W = 16,
  parameter int NSTEP_W = 10,
  parameter int SATURATE = 0,
  localparam int CMD_W = 2*FREQ_W+DWELL_W+NSTEP_W+2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CMD_W-1:0]   fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic               abort,
  output logic [FREQ_W-1:0]  dds_freq,
  output logic [NSTEP_W-1:0] step_index,
  output logic               sweep_start,
  output logic               step_strobe,
  output logic               sweep_wrap,
  output logic               sweep_done,
  output logic               sweep_aborted,
  output logic               busy
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_LOAD, S_RUN} state_t;
  state_t r_state;
  logic [FREQ_W-1:0] r_init, r_step;
  logic [DWELL_W-1:0] r_dwell, r_cnt;
  logic [NSTEP_W-1:0] r_nsteps;
  logic [1:0] r_mode;
  logic r_dir;
  logic w_neg, w_end;
  logic signed [FREQ_W+1:0] w_delta, w_sum;
  logic [FREQ_W-1:0] w_next;
  // The top-of-triangle turn subtracts on the same edge that flips direction
  assign w_neg = r_dir || (step_index == r_nsteps);
  assign w_end = r_dir ? (step_index == '0) : (step_index == r_nsteps && (!r_mode[1] || r_nsteps == '0));
  always_comb begin
    w_delta = $signed({{2{r_step[FREQ_W-1]}}, r_step});
    w_sum = $signed({2'b00, dds_freq}) + (w_neg ? -w_delta : w_delta);
    w_next = (SATURATE != 0 && w_sum[FREQ_W+1]) ? '0 :
             (SATURATE != 0 && w_sum[FREQ_W]) ? '1 : w_sum[FREQ_W-1:0];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_init <= '0;
      r_step <= '0;
      r_dwell <= '0;
      r_cnt <= '0;
      r_nsteps <= '0;
      r_mode <= '0;
      r_dir <= 1'b0;
      fifo_rd_en <= 1'b0;
      dds_freq <= '0;
      step_index <= '0;
      sweep_start <= 1'b0;
      step_strobe <= 1'b0;
      sweep_wrap <= 1'b0;
      sweep_done <= 1'b0;
      sweep_aborted <= 1'b0;
      busy <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      sweep_start <= 1'b0;
      step_strobe <= 1'b0;
      sweep_wrap <= 1'b0;
      sweep_done <= 1'b0;
      sweep_aborted <= 1'b0;
      case (r_state)
        S_IDLE: if (!fifo_empty) begin
          fifo_rd_en <= 1'b1;
          busy <= 1'b1;
          r_state <= S_READ;
        end
        S_READ, S_LOAD: if (abort) begin
          sweep_aborted <= 1'b1;
          busy <= 1'b0;
          r_state <= S_IDLE;
        end else if (r_state == S_READ) begin
          r_state <= S_LOAD;
        end else begin
          {r_init, r_step, r_dwell, r_nsteps, r_mode} <= fifo_data;
          dds_freq <= fifo_data[CMD_W-1 -: FREQ_W];
          step_index <= '0;
          r_cnt <= '0;
          r_dir <= 1'b0;
          sweep_start <= 1'b1;
          step_strobe <= 1'b1;
          r_state <= S_RUN;
        end
        S_RUN: if (abort) begin
          sweep_aborted <= 1'b1;
          busy <= 1'b0;
          r_state <= S_IDLE;
        end else if (r_cnt != r_dwell) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
          if (w_end && r_mode[0]) begin
            dds_freq <= r_init;
            step_index <= '0;
            r_dir <= 1'b0;
            sweep_wrap <= 1'b1;
            step_strobe <= 1'b1;
          end else if (w_end) begin
            sweep_done <= 1'b1;
            busy <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            dds_freq <= w_next;
            step_strobe <= 1'b1;
            r_dir <= w_neg;
            step_index <= w_neg ? step_index - 1'b1 : step_index + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frequency_sweeper_multimode.sv
// tb_frequency_sweeper_multimode: wrapping and clamping sweepers run side by side against
// a point-list reference model expanded into per-cycle expectations.
module tb_frequency_sweeper_multimode;
  localparam int CMD_W = 92;
  typedef logic [48:0] vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic fifo_empty = 1'b1;
  logic abort = 1'b0;
  logic [CMD_W-1:0] fifo_data = '0;
  logic rd_en[2], start[2], strobe[2], wrap[2], done[2], aborted[2], busy[2];
  logic [31:0] freq[2];
  logic [9:0] idx[2];
  vec_t ov[2];
  vec_t eq[2][$];
  logic [CMD_W-1:0] fq[$];
  logic [31:0] lf[2];
  logic [9:0] li[2];
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    frequency_sweeper_multimode #(.SATURATE(g)) u_dut (
      .clk(clk), .reset_n(reset_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_rd_en(rd_en[g]), .abort(abort), .dds_freq(freq[g]), .step_index(idx[g]),
      .sweep_start(start[g]), .step_strobe(strobe[g]), .sweep_wrap(wrap[g]),
      .sweep_done(done[g]), .sweep_aborted(aborted[g]), .busy(busy[g]));
    assign ov[g] = {freq[g], idx[g], start[g], strobe[g], wrap[g], done[g], aborted[g], busy[g], rd_en[g]};
  end
  // Advance to the next falling edge; the FIFO model answers a pop strobe seen there
  task automatic step();
    @(negedge clk);
    if (rd_en[0] && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask
  task automatic push(input logic [CMD_W-1:0] c);
    fq.push_back(c);
    fifo_empty = 1'b0;
  endtask
  function automatic logic [CMD_W-1:0] mk(input logic [31:0] init, input logic [31:0] st, input int dw, input int n, input int mode);
    return {init, st, 16'(dw), 10'(n), 2'(mode)};
  endfunction
  function automatic logic [31:0] arith(input logic [31:0] f, input logic [31:0] st, input bit neg, input bit sat);
    longint s;
    s = longint'({32'b0, f}) + (neg ? -longint'($signed(st)) : longint'($signed(st)));
    if (sat && s < 0) return 32'h0;
    if (sat && s > 64'sh0FFFFFFFF) return 32'hFFFFFFFF;
    return 32'(s);
  endfunction
  // Expected outputs from the LOAD edge on: period point list, each point dwell+1 cycles
  task automatic gen(input logic [CMD_W-1:0] c, input int ncyc);
    logic [31:0] pf[$];
    int pi[$];
    logic [31:0] f;
    int n, dw;
    bit first;
    n = int'(c[11:2]);
    dw = int'(c[27:12]);
    for (int s = 0; s < 2; s++) begin
      pf = {};
      pi = {};
      f = c[91:60];
      pf.push_back(f);
      pi.push_back(0);
      for (int k = 1; k <= n; k++) begin
        f = arith(f, c[59:28], 1'b0, s == 1);
        pf.push_back(f);
        pi.push_back(k);
      end
      if (c[1]) for (int k = n - 1; k >= 0; k--) begin
        f = arith(f, c[59:28], 1'b1, s == 1);
        pf.push_back(f);
        pi.push_back(k);
      end
      eq[s] = {};
      do begin
        for (int p = 0; p < pf.size(); p++) for (int d = 0; d <= dw; d++) begin
          first = (eq[s].size() == 0);
          eq[s].push_back({pf[p], 10'(pi[p]), first, d == 0, p == 0 && d == 0 && !first, 4'b0010});
        end
      end while (c[0] && eq[s].size() < ncyc);
      if (!c[0]) eq[s].push_back({pf[pf.size()-1], 10'(pi[pi.size()-1]), 7'b0001000});
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      nvec++;
      if (ov[s] !== '0) begin nerr++; $display("FAIL reset dut%0d: got %h want 0", s, ov[s]); end
      lf[s] = '0;
      li[s] = '0;
    end
    reset_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      for (int s = 0; s < 2; s++) begin
        nvec++;
        if (ov[s] !== '0) begin nerr++; $display("FAIL idle_empty dut%0d cyc%0d: got %h want 0", s, t, ov[s]); end
      end
    end
  endtask
  task automatic test_sweeps();
    logic [CMD_W-1:0] dc[$], c;
    int dn[$], da[$];
    int nc, ab, last;
    vec_t ev;
    dc.push_back(mk(1000, 10, 2, 3, 0));                   dn.push_back(0);  da.push_back(-1);
    dc.push_back(mk(500, 32'hFFFFFFFB, 0, 2, 2));          dn.push_back(0);  da.push_back(-1);
    dc.push_back(mk(32'hFFFFFFF0, 32'h20, 0, 1, 0));       dn.push_back(0);  da.push_back(-1);
    dc.push_back(mk(32'h10, 32'hFFFFFFE0, 0, 1, 0));       dn.push_back(0);  da.push_back(-1);
    dc.push_back(mk(32'hFFFFFFF0, 32'h20, 1, 1, 2));       dn.push_back(0);  da.push_back(-1);
    dc.push_back(mk(77, 3, 3, 0, 2));                      dn.push_back(0);  da.push_back(-1);
    dc.push_back(mk(0, 1, 1, 1, 1));                       dn.push_back(12); da.push_back(9);
    dc.push_back(mk(0, 1, 1, 1, 1));                       dn.push_back(12); da.push_back(6);
    dc.push_back(mk(100, 7, 0, 2, 3));                     dn.push_back(12); da.push_back(11);
    for (int k = 0; k < dc.size() + 25; k++) begin
      if (k < dc.size()) begin
        c = dc[k];
        nc = dn[k];
        ab = da[k];
        gen(c, nc);
      end else begin
        c = mk($urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
        nc = c[0] ? int'($urandom_range(4, 20)) : 0;
        gen(c, nc);
        if (c[0]) ab = int'($urandom_range(0, nc - 1));
        else if ($urandom_range(0, 2) == 0) ab = int'($urandom_range(0, eq[0].size() - 2));
        else ab = -1;
      end
      push(c);
      for (int t = 1; t <= 3; t++) begin
        step();
        for (int s = 0; s < 2; s++) begin
          ev = (t == 3) ? eq[s][0] : {lf[s], li[s], 5'b0, 1'b1, t == 1};
          nvec++;
          if (ov[s] !== ev) begin nerr++; $display("FAIL sweep%0d launch%0d dut%0d: got %h want %h", k, t, s, ov[s], ev); end
        end
      end
      last = (ab >= 0) ? ab : eq[0].size() - 1;
      for (int j = 1; j <= last; j++) begin
        step();
        for (int s = 0; s < 2; s++) begin
          nvec++;
          if (ov[s] !== eq[s][j]) begin nerr++; $display("FAIL sweep%0d pt%0d dut%0d: got %h want %h", k, j, s, ov[s], eq[s][j]); end
        end
      end
      for (int s = 0; s < 2; s++) begin
        lf[s] = eq[s][last][48:17];
        li[s] = eq[s][last][16:7];
      end
      if (ab >= 0) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int s = 0; s < 2; s++) begin
          ev = {lf[s], li[s], 7'b0000100};
          nvec++;
          if (ov[s] !== ev) begin nerr++; $display("FAIL sweep%0d abort dut%0d: got %h want %h", k, s, ov[s], ev); end
        end
      end
    end
  endtask
  task automatic test_abort_load();
    vec_t ev;
    for (int p = 1; p <= 2; p++) begin
      push(mk(1234, 5, 0, 2, 0));
      for (int t = 1; t <= p; t++) begin
        step();
        for (int s = 0; s < 2; s++) begin
          ev = {lf[s], li[s], 5'b0, 1'b1, t == 1};
          nvec++;
          if (ov[s] !== ev) begin nerr++; $display("FAIL abort_load%0d pre%0d dut%0d: got %h want %h", p, t, s, ov[s], ev); end
        end
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      for (int s = 0; s < 2; s++) begin
        ev = {lf[s], li[s], 7'b0000100};
        nvec++;
        if (ov[s] !== ev) begin nerr++; $display("FAIL abort_load%0d pulse dut%0d: got %h want %h", p, s, ov[s], ev); end
      end
      for (int t = 0; t < 4; t++) begin
        step();
        for (int s = 0; s < 2; s++) begin
          ev = {lf[s], li[s], 7'b0};
          nvec++;
          if (ov[s] !== ev) begin nerr++; $display("FAIL abort_load%0d after%0d dut%0d: got %h want %h", p, t, s, ov[s], ev); end
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [CMD_W-1:0] c[2];
    vec_t ev;
    c[0] = mk($urandom, 32'($urandom_range(0, 200)) - 32'd100, 1, 2, 0);
    c[1] = mk($urandom, $urandom, 0, 3, 2);
    push(c[0]);
    push(c[1]);
    for (int k = 0; k < 2; k++) begin
      gen(c[k], 0);
      for (int t = 1; t <= 3; t++) begin
        step();
        for (int s = 0; s < 2; s++) begin
          ev = (t == 3) ? eq[s][0] : {lf[s], li[s], 5'b0, 1'b1, t == 1};
          nvec++;
          if (ov[s] !== ev) begin nerr++; $display("FAIL b2b%0d launch%0d dut%0d: got %h want %h", k, t, s, ov[s], ev); end
        end
      end
      for (int j = 1; j < eq[0].size(); j++) begin
        step();
        for (int s = 0; s < 2; s++) begin
          nvec++;
          if (ov[s] !== eq[s][j]) begin nerr++; $display("FAIL b2b%0d pt%0d dut%0d: got %h want %h", k, j, s, ov[s], eq[s][j]); end
        end
      end
      for (int s = 0; s < 2; s++) begin
        lf[s] = eq[s][eq[s].size()-1][48:17];
        li[s] = eq[s][eq[s].size()-1][16:7];
      end
    end
    for (int t = 0; t < 4; t++) begin
      step();
      for (int s = 0; s < 2; s++) begin
        ev = {lf[s], li[s], 7'b0};
        nvec++;
        if (ov[s] !== ev) begin nerr++; $display("FAIL b2b empty%0d dut%0d: got %h want %h", t, s, ov[s], ev); end
      end
    end
  endtask
  task automatic test_async_reset();
    logic [CMD_W-1:0] c;
    push(mk(1000, 10, 2, 3, 0));
    repeat (6) step();
    #2 reset_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      nvec++;
      if (ov[s] !== '0) begin nerr++; $display("FAIL async_reset dut%0d: got %h want 0", s, ov[s]); end
      lf[s] = '0;
      li[s] = '0;
    end
    step();
    reset_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      for (int s = 0; s < 2; s++) begin
        nvec++;
        if (ov[s] !== '0) begin nerr++; $display("FAIL post_reset idle%0d dut%0d: got %h want 0", t, s, ov[s]); end
      end
    end
    c = mk(32'hFFFFFF00, 32'h80, 0, 3, 2);
    gen(c, 0);
    push(c);
    repeat (2) step();
    for (int j = 0; j < eq[0].size(); j++) begin
      step();
      for (int s = 0; s < 2; s++) begin
        nvec++;
        if (ov[s] !== eq[s][j]) begin nerr++; $display("FAIL post_reset pt%0d dut%0d: got %h want %h", j, s, ov[s], eq[s][j]); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_sweeps();
    test_abort_load();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
